// File: rtl/addsub_pkg.sv
// Shared command encodings and output-stage state type for the add/sub accumulator.
package addsub_pkg;

    typedef enum logic [1:0] {
        CMD_CLEAR = 2'b00,
        CMD_LOAD  = 2'b01,
        CMD_ADD   = 2'b10,
        CMD_SUB   = 2'b11
    } cmd_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

endpackage

// File: rtl/addsub_core.sv
// Combinational N-bit ripple adder-subtractor: s = a + (b ^ {N{sub}}) + sub.
module addsub_core #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    logic [N-1:0] bx;
    logic [N:0]   c;

    always_comb begin
        bx   = b ^ {N{sub}};
        c    = '0;
        c[0] = sub;
        s    = '0;
        for (int unsigned i = 0; i < N; i++) begin
            s[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1] = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        cout = c[N];
        // Signed overflow: operands agree in sign but the result does not.
        ovf  = (a[N-1] == bx[N-1]) && (s[N-1] != a[N-1]);
    end

endmodule

// File: rtl/addsub_accumulator.sv
// Back-pressured accumulator stage (CLEAR/LOAD/ADD/SUB) around addsub_core.
// Define ADDSUB_ACC_SATURATE_EN to saturate acc on signed overflow instead of wrapping.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int unsigned N     = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_cmd,
    input  logic [N-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     acc,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [CNT_W-1:0] op_cnt
);

    state_e           state_q;
    logic [N-1:0]     acc_q, acc_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             sub;
    logic [N-1:0]     core_s;
    logic             core_cout, core_ovf;

    assign out_valid = (state_q == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign sub       = (in_cmd == CMD_SUB);

    addsub_core #(.N(N)) u_core (
        .a    (acc_q),
        .b    (in_data),
        .sub  (sub),
        .s    (core_s),
        .cout (core_cout),
        .ovf  (core_ovf)
    );

    always_comb begin
        acc_d  = '0;
        cout_d = 1'b0;
        ovf_d  = 1'b0;
        case (in_cmd)
            CMD_CLEAR: acc_d = '0;
            CMD_LOAD:  acc_d = in_data;
            default: begin
                acc_d  = core_s;
                cout_d = core_cout;
                ovf_d  = core_ovf;
`ifdef ADDSUB_ACC_SATURATE_EN
                // Clamp toward the sign of the accumulator operand.
                if (core_ovf) begin
                    acc_d = acc_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
                end
`endif
            end
        endcase
        zero_d = (acc_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b1;
            cnt_q   <= '0;
        end else if (accept) begin
            state_q <= FULL;
            acc_q   <= acc_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            cnt_q   <= cnt_q + CNT_W'(1);
        end else if (out_ready) begin
            state_q <= EMPTY;
        end
    end

    assign acc    = acc_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;
    assign op_cnt = cnt_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator (N=4, CNT_W=2 so op_cnt wraps quickly).
// Overflow expectations follow ADDSUB_ACC_SATURATE_EN when it is defined.
module tb_addsub_accumulator;

`ifdef ADDSUB_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_cmd;
    logic [3:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] acc;
    logic       cout;
    logic       ovf;
    logic       zero;
    logic [1:0] op_cnt;

    int n_vec = 0;
    int n_err = 0;

    addsub_accumulator #(.N(4), .CNT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc       (acc),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Present one command, let it be accepted on the next edge, then drop valid.
    task automatic issue(input logic [1:0] c, input logic [3:0] d);
        in_valid = 1'b1;
        in_cmd   = c;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [3:0] a, input logic c,
                           input logic o, input logic z, input logic [1:0] n);
        chk({tag, ".acc"},  8'(acc),       8'(a));
        chk({tag, ".cout"}, 8'(cout),      8'(c));
        chk({tag, ".ovf"},  8'(ovf),       8'(o));
        chk({tag, ".zero"}, 8'(zero),      8'(z));
        chk({tag, ".cnt"},  8'(op_cnt),    8'(n));
        chk({tag, ".ov"},   8'(out_valid), 8'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cmd    = 2'b00;
        in_data   = 4'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.acc",  8'(acc),       8'd0);
        chk("rst.zero", 8'(zero),      8'd1);
        chk("rst.ov",   8'(out_valid), 8'd0);
        chk("rst.cnt",  8'(op_cnt),    8'd0);
        chk("rst.ir",   8'(in_ready),  8'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b01, 4'd3);  chk_res("load3", 4'd3, 1'b0, 1'b0, 1'b0, 2'd1);
        issue(2'b10, 4'd4);  chk_res("add4",  4'd7, 1'b0, 1'b0, 1'b0, 2'd2);
        issue(2'b11, 4'd7);  chk_res("sub7",  4'd0, 1'b1, 1'b0, 1'b1, 2'd3);
        issue(2'b01, 4'd7);  chk_res("load7", 4'd7, 1'b0, 1'b0, 1'b0, 2'd0);
        issue(2'b10, 4'd1);  chk_res("add1ov", SAT ? 4'd7 : 4'd8, 1'b0, 1'b1, 1'b0, 2'd1);
        issue(2'b01, 4'd8);  chk_res("load8", 4'd8, 1'b0, 1'b0, 1'b0, 2'd2);
        issue(2'b11, 4'd1);  chk_res("sub1ov", SAT ? 4'd8 : 4'd7, 1'b1, 1'b1, 1'b0, 2'd3);

        @(posedge clk); #1;
        chk("drain.ov", 8'(out_valid), 8'd0);
        chk("drain.ir", 8'(in_ready),  8'd1);

        issue(2'b01, 4'd5);  chk_res("load5", 4'd5, 1'b0, 1'b0, 1'b0, 2'd0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_cmd    = 2'b10;
        in_data   = 4'd2;
        #1;
        chk("bp0.ir", 8'(in_ready), 8'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp.ir",  8'(in_ready),  8'd0);
            chk("bp.acc", 8'(acc),       8'd5);
            chk("bp.ov",  8'(out_valid), 8'd1);
            chk("bp.cnt", 8'(op_cnt),    8'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bprel.ir", 8'(in_ready), 8'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_res("bpadd2", 4'd7, 1'b0, 1'b0, 1'b0, 2'd1);

        issue(2'b11, 4'd1);  chk_res("sub1",  4'd6, 1'b1, 1'b0, 1'b0, 2'd2);
        issue(2'b10, 4'd2);  chk_res("add2ov", SAT ? 4'd7 : 4'd8, 1'b0, 1'b1, 1'b0, 2'd3);
        issue(2'b00, 4'd9);  chk_res("clear", 4'd0, 1'b0, 1'b0, 1'b1, 2'd0);

        issue(2'b01, 4'd9);  chk_res("load9", 4'd9, 1'b0, 1'b0, 1'b0, 2'd1);
        out_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.acc",  8'(acc),       8'd0);
        chk("mrst.zero", 8'(zero),      8'd1);
        chk("mrst.ov",   8'(out_valid), 8'd0);
        chk("mrst.cnt",  8'(op_cnt),    8'd0);
        chk("mrst.cout", 8'(cout),      8'd0);
        chk("mrst.ovf",  8'(ovf),       8'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post.ov",  8'(out_valid), 8'd0);
        chk("post.acc", 8'(acc),       8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
